// File: rtl/dataflow_taint_sink.sv
// dataflow_taint_sink: receiving end of the two-stream data-flow test interface.
// Accepts up to two valid-qualified words per cycle (in1 before in2) into an
// in-order FIFO with a ready/valid drain port, and tracks drops and taint.
// Head outputs come straight from storage registers indexed by the read pointer.

module dataflow_taint_sink #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data_t0,
    input  logic              in1_valid_t0,
    input  logic [DATA_W-1:0] in2_data,
    input  logic              in2_valid,
    input  logic [DATA_W-1:0] in2_data_t0,
    input  logic              in2_valid_t0,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] out_data_t0,
    output logic              out_ctl_t0,
    output logic              out_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  taint_cnt,
    output logic              taint_alarm,
    input  logic              alarm_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    // FIFO storage, deliberately not reset
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [DATA_W-1:0] mem_dt0  [DEPTH];
    logic              mem_vt0  [DEPTH];
    logic              mem_src  [DEPTH];

    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    cnt_t             count_q, count_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] taint_cnt_q, taint_cnt_d;
    logic             alarm_q, alarm_d;

    logic       pop;
    cnt_t       space;
    logic       taint1, taint2;
    logic       acc1, acc2;
    logic       drop1, drop2;
    cnt_t       n_acc;
    ptr_t       wr1_addr, wr2_addr;
    logic [1:0] taint_add, drop_add;
    logic       alarm_set;

    // Saturating accumulate; a sum past the top clamps to all-ones
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Accept/drop decision, write slots, counter and alarm next state
    always_comb begin
        pop    = out_valid & out_ready;
        // A pop frees its slot for this cycle's pushes
        space  = cnt_t'(DEPTH) - count_q + cnt_t'(pop);
        taint1 = (|in1_data_t0) | in1_valid_t0;
        taint2 = (|in2_data_t0) | in2_valid_t0;
        acc1   = in1_valid && (space != '0);
        acc2   = in2_valid && (in1_valid ? (space >= cnt_t'(2)) : (space != '0));
        drop1  = in1_valid & ~acc1;
        drop2  = in2_valid & ~acc2;
        n_acc  = cnt_t'(acc1) + cnt_t'(acc2);

        wr1_addr = wr_ptr_q;
        // in2 lands right after in1 when both are accepted
        wr2_addr = acc1 ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;

        wr_ptr_d = wr_ptr_q + ptr_t'(n_acc);
        rd_ptr_d = rd_ptr_q + ptr_t'(pop);
        count_d  = count_q - cnt_t'(pop) + n_acc;

        taint_add = {1'b0, acc1 & taint1} + {1'b0, acc2 & taint2};
        drop_add  = {1'b0, drop1} + {1'b0, drop2};

        drop_cnt_d  = sat_add(drop_cnt_q, drop_add);
        taint_cnt_d = sat_add(taint_cnt_q, taint_add);

        // Tainted control counts even without its valid; dropped taint still alarms
        alarm_set = (acc1 & taint1) | (acc2 & taint2) |
                    (drop1 & taint1) | (drop2 & taint2) |
                    in1_valid_t0 | in2_valid_t0;
        alarm_d   = alarm_set | (alarm_q & ~alarm_clr);
    end

    // Control state: pointers, occupancy, counters and sticky alarm
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drop_cnt_q  <= '0;
            taint_cnt_q <= '0;
            alarm_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drop_cnt_q  <= drop_cnt_d;
            taint_cnt_q <= taint_cnt_d;
            alarm_q     <= alarm_d;
        end
    end

    // Storage write: up to two entries per cycle into distinct slots
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (acc2 && (wr2_addr == ptr_t'(i))) begin
                mem_data[i] <= in2_data;
                mem_dt0[i]  <= in2_data_t0;
                mem_vt0[i]  <= in2_valid_t0;
                mem_src[i]  <= 1'b1;
            end else if (acc1 && (wr1_addr == ptr_t'(i))) begin
                mem_data[i] <= in1_data;
                mem_dt0[i]  <= in1_data_t0;
                mem_vt0[i]  <= in1_valid_t0;
                mem_src[i]  <= 1'b0;
            end
        end
    end

    assign out_data    = mem_data[rd_ptr_q];
    assign out_data_t0 = mem_dt0[rd_ptr_q];
    assign out_ctl_t0  = mem_vt0[rd_ptr_q];
    assign out_src     = mem_src[rd_ptr_q];
    assign out_valid   = (count_q != '0);
    assign drop_cnt    = drop_cnt_q;
    assign taint_cnt   = taint_cnt_q;
    assign taint_alarm = alarm_q;

endmodule

// File: tb/tb_dataflow_taint_sink.sv
// Directed bench for dataflow_taint_sink: a default instance (DEPTH 4, CNT_W 16)
// and a CNT_W = 2 instance for counter saturation.

module tb_dataflow_taint_sink;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] in1_data, in1_data_t0, in2_data, in2_data_t0;
    logic        in1_valid, in1_valid_t0, in2_valid, in2_valid_t0;
    logic [31:0] out_data, out_data_t0;
    logic        out_ctl_t0, out_src, out_valid, out_ready;
    logic [15:0] drop_cnt, taint_cnt;
    logic        taint_alarm, alarm_clr;

    logic [31:0] s_in1_data, s_in1_data_t0, s_in2_data, s_in2_data_t0;
    logic        s_in1_valid, s_in1_valid_t0, s_in2_valid, s_in2_valid_t0;
    logic [31:0] s_out_data, s_out_data_t0;
    logic        s_out_ctl_t0, s_out_src, s_out_valid, s_out_ready;
    logic [1:0]  s_drop_cnt, s_taint_cnt;
    logic        s_taint_alarm, s_alarm_clr;

    int vectors    = 0;
    int miscompare = 0;

    always #5 clk = ~clk;

    dataflow_taint_sink u_dut (
        .clk(clk), .rst(rst),
        .in1_data(in1_data), .in1_valid(in1_valid),
        .in1_data_t0(in1_data_t0), .in1_valid_t0(in1_valid_t0),
        .in2_data(in2_data), .in2_valid(in2_valid),
        .in2_data_t0(in2_data_t0), .in2_valid_t0(in2_valid_t0),
        .out_data(out_data), .out_data_t0(out_data_t0), .out_ctl_t0(out_ctl_t0),
        .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready),
        .drop_cnt(drop_cnt), .taint_cnt(taint_cnt),
        .taint_alarm(taint_alarm), .alarm_clr(alarm_clr)
    );

    dataflow_taint_sink #(.DATA_W(32), .DEPTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .in1_data(s_in1_data), .in1_valid(s_in1_valid),
        .in1_data_t0(s_in1_data_t0), .in1_valid_t0(s_in1_valid_t0),
        .in2_data(s_in2_data), .in2_valid(s_in2_valid),
        .in2_data_t0(s_in2_data_t0), .in2_valid_t0(s_in2_valid_t0),
        .out_data(s_out_data), .out_data_t0(s_out_data_t0), .out_ctl_t0(s_out_ctl_t0),
        .out_src(s_out_src), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .drop_cnt(s_drop_cnt), .taint_cnt(s_taint_cnt),
        .taint_alarm(s_taint_alarm), .alarm_clr(s_alarm_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in1_data = '0; in1_data_t0 = '0; in1_valid = 0; in1_valid_t0 = 0;
        in2_data = '0; in2_data_t0 = '0; in2_valid = 0; in2_valid_t0 = 0;
        alarm_clr = 0;
        s_in1_data = '0; s_in1_data_t0 = '0; s_in1_valid = 0; s_in1_valid_t0 = 0;
        s_in2_data = '0; s_in2_data_t0 = '0; s_in2_valid = 0; s_in2_valid_t0 = 0;
        s_alarm_clr = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b0 || drop_cnt !== 16'd0 || taint_cnt !== 16'd0 ||
            taint_alarm !== 1'b0) begin
            miscompare++;
            $display("FAIL reset: valid=%b drop=%0d taint=%0d alarm=%b, required 0/0/0/0",
                     out_valid, drop_cnt, taint_cnt, taint_alarm);
        end
        rst = 1;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || drop_cnt !== 16'd0 || taint_alarm !== 1'b0) begin
            miscompare++;
            $display("FAIL reset_release: valid=%b drop=%0d alarm=%b, required 0/0/0",
                     out_valid, drop_cnt, taint_alarm);
        end
    endtask

    task automatic test_ordering();
        out_ready = 0;
        in1_data = 32'hdeadbeef; in1_valid = 1;
        in2_data = 32'hffffffff; in2_valid = 1;
        tick();
        clear_inputs();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'hdeadbeef || out_src !== 1'b0) begin
            miscompare++;
            $display("FAIL order_head0: valid=%b data=%h src=%b, required 1/deadbeef/0",
                     out_valid, out_data, out_src);
        end
        out_ready = 1;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'hffffffff || out_src !== 1'b1) begin
            miscompare++;
            $display("FAIL order_head1: valid=%b data=%h src=%b, required 1/ffffffff/1",
                     out_valid, out_data, out_src);
        end
        tick();
        out_ready = 0;
        vectors++;
        if (out_valid !== 1'b0 || taint_cnt !== 16'd0) begin
            miscompare++;
            $display("FAIL order_empty: valid=%b taint=%0d, required 0/0", out_valid, taint_cnt);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_data [4];
        logic        exp_src  [4];
        exp_data[0] = 32'h101; exp_src[0] = 0;
        exp_data[1] = 32'h201; exp_src[1] = 1;
        exp_data[2] = 32'h102; exp_src[2] = 0;
        exp_data[3] = 32'h202; exp_src[3] = 1;
        out_ready = 0;
        for (int k = 1; k <= 3; k++) begin
            in1_data = 32'h100 + k; in1_valid = 1;
            in2_data = 32'h200 + k; in2_valid = 1;
            tick();
            if (k == 2) begin
                vectors++;
                if (drop_cnt !== 16'd0) begin
                    miscompare++;
                    $display("FAIL ovf_no_drop_yet: drop=%0d, required 0", drop_cnt);
                end
            end
        end
        clear_inputs();
        vectors++;
        if (drop_cnt !== 16'd2) begin
            miscompare++;
            $display("FAIL ovf_drop: drop=%0d, required 2", drop_cnt);
        end
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exp_data[k] || out_src !== exp_src[k]) begin
                miscompare++;
                $display("FAIL ovf_drain%0d: valid=%b data=%h src=%b, required 1/%h/%b",
                         k, out_valid, out_data, out_src, exp_data[k], exp_src[k]);
            end
            tick();
        end
        out_ready = 0;
        vectors++;
        if (out_valid !== 1'b0 || drop_cnt !== 16'd2) begin
            miscompare++;
            $display("FAIL ovf_empty: valid=%b drop=%0d, required 0/2", out_valid, drop_cnt);
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] exp_data [4];
        exp_data[0] = 32'd3; exp_data[1] = 32'd4; exp_data[2] = 32'd5; exp_data[3] = 32'd6;
        out_ready = 0;
        in1_data = 32'd1; in1_valid = 1; in2_data = 32'd2; in2_valid = 1;
        tick();
        in1_data = 32'd3; in2_data = 32'd4;
        tick();
        clear_inputs();
        // Full: pop plus a single push is accepted
        out_ready = 1;
        in1_data = 32'd5; in1_valid = 1;
        tick();
        vectors++;
        if (drop_cnt !== 16'd2 || out_data !== 32'd2) begin
            miscompare++;
            $display("FAIL full_pop_push1: drop=%0d head=%0d, required 2/2", drop_cnt, out_data);
        end
        // Full: pop plus two pushes keeps in1, drops in2
        in1_data = 32'd6; in2_data = 32'd7; in2_valid = 1;
        tick();
        clear_inputs();
        vectors++;
        if (drop_cnt !== 16'd3 || out_data !== 32'd3) begin
            miscompare++;
            $display("FAIL full_pop_push2: drop=%0d head=%0d, required 3/3", drop_cnt, out_data);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exp_data[k]) begin
                miscompare++;
                $display("FAIL full_drain%0d: valid=%b data=%0d, required 1/%0d",
                         k, out_valid, out_data, exp_data[k]);
            end
            tick();
        end
        out_ready = 0;
        vectors++;
        if (out_valid !== 1'b0 || taint_cnt !== 16'd0 || taint_alarm !== 1'b0) begin
            miscompare++;
            $display("FAIL full_empty: valid=%b taint=%0d alarm=%b, required 0/0/0",
                     out_valid, taint_cnt, taint_alarm);
        end
    endtask

    task automatic test_data_taint();
        out_ready = 0;
        in1_data = 32'hdeadbeef; in1_data_t0 = 32'hffffffff; in1_valid = 1;
        tick();
        clear_inputs();
        vectors++;
        if (out_data !== 32'hdeadbeef || out_data_t0 !== 32'hffffffff || out_ctl_t0 !== 1'b0 ||
            taint_cnt !== 16'd1 || taint_alarm !== 1'b1) begin
            miscompare++;
            $display("FAIL data_taint: d=%h t0=%h ct=%b cnt=%0d alarm=%b, required deadbeef/ffffffff/0/1/1",
                     out_data, out_data_t0, out_ctl_t0, taint_cnt, taint_alarm);
        end
        alarm_clr = 1;
        tick();
        alarm_clr = 0;
        vectors++;
        if (taint_alarm !== 1'b0 || taint_cnt !== 16'd1) begin
            miscompare++;
            $display("FAIL data_taint_clr: alarm=%b cnt=%0d, required 0/1", taint_alarm, taint_cnt);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic test_ctl_taint();
        in2_valid = 0; in2_valid_t0 = 1; alarm_clr = 1;
        tick();
        clear_inputs();
        vectors++;
        if (out_valid !== 1'b0 || taint_cnt !== 16'd1 || taint_alarm !== 1'b1) begin
            miscompare++;
            $display("FAIL ctl_taint: valid=%b cnt=%0d alarm=%b, required 0/1/1",
                     out_valid, taint_cnt, taint_alarm);
        end
        alarm_clr = 1;
        tick();
        alarm_clr = 0;
        // Fill with clean words, then drop a tainted one
        out_ready = 0;
        in1_data = 32'ha; in1_valid = 1; in2_data = 32'hb; in2_valid = 1;
        tick();
        tick();
        clear_inputs();
        in1_data = 32'hc; in1_data_t0 = 32'h1; in1_valid = 1;
        tick();
        clear_inputs();
        vectors++;
        if (drop_cnt !== 16'd4 || taint_cnt !== 16'd1 || taint_alarm !== 1'b1) begin
            miscompare++;
            $display("FAIL drop_taint: drop=%0d cnt=%0d alarm=%b, required 4/1/1",
                     drop_cnt, taint_cnt, taint_alarm);
        end
        out_ready = 1; alarm_clr = 1;
        repeat (4) tick();
        out_ready = 0; alarm_clr = 0;
    endtask

    task automatic test_reset_mid();
        out_ready = 0;
        in1_data = 32'h1; in1_valid = 1; in2_data = 32'h2; in2_valid = 1;
        tick();
        in2_valid = 0; in1_valid_t0 = 1;
        tick();
        clear_inputs();
        vectors++;
        if (out_valid !== 1'b1 || taint_alarm !== 1'b1) begin
            miscompare++;
            $display("FAIL rst_mid_pre: valid=%b alarm=%b, required 1/1", out_valid, taint_alarm);
        end
        rst = 0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || drop_cnt !== 16'd0 || taint_cnt !== 16'd0 ||
            taint_alarm !== 1'b0) begin
            miscompare++;
            $display("FAIL rst_mid: valid=%b drop=%0d taint=%0d alarm=%b, required 0/0/0/0",
                     out_valid, drop_cnt, taint_cnt, taint_alarm);
        end
        tick();
        rst = 1;
        tick();
    endtask

    task automatic test_saturation();
        logic [1:0] exp_taint [6];
        exp_taint[0] = 2'd2; exp_taint[1] = 2'd2; exp_taint[2] = 2'd3;
        exp_taint[3] = 2'd3; exp_taint[4] = 2'd3; exp_taint[5] = 2'd3;
        s_out_ready = 1;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                s_in1_data = 32'h10 + k; s_in1_data_t0 = 32'h1; s_in1_valid = 1;
                s_in2_data = 32'h20 + k; s_in2_valid_t0 = 1; s_in2_valid = 1;
            end else begin
                clear_inputs();
            end
            tick();
            vectors++;
            if (s_taint_cnt !== exp_taint[k]) begin
                miscompare++;
                $display("FAIL sat_taint%0d: taint=%0d, required %0d",
                         k, s_taint_cnt, exp_taint[k]);
            end
        end
        clear_inputs();
        vectors++;
        if (s_drop_cnt !== 2'd0 || s_taint_alarm !== 1'b1) begin
            miscompare++;
            $display("FAIL sat_drop: drop=%0d alarm=%b, required 0/1", s_drop_cnt, s_taint_alarm);
        end
    endtask

    initial begin
        rst = 0;
        out_ready = 0;
        s_out_ready = 0;
        clear_inputs();
        test_reset();
        test_ordering();
        test_overflow();
        test_full_pop();
        test_data_taint();
        test_ctl_taint();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompare);
        $finish;
    end

endmodule
